core_sequencer: RTL
===================

// Module: core_sequencer
// PURPOSE
//  Multi-cycle control FSM for the unpipelined RV32I core. It steps one instruction through
//  FETCH->DECODE->EXEC->(MEM)->WB. It issues req/ack handshakes to instruction and data memory.
//  It pulses the IR, register-file and PC write enables that the ID/EX/WB datapath consumes.
//  It traps on illegal opcodes and memory timeouts, and counts retired instructions.
// PARAMETERS
//  MEM_TIMEOUT  16  max cycles a memory req may wait for ack; 0 disables the timeout
//  CNT_W        32  width of the instret counter
// PORTS
//  clk         in   1      core clock, rising edge
//  rst         in   1      asynchronous, active-low reset
//  hold        in   1      external stall; blocks the start of the next instruction
//  opcode      in   7      instr[6:0] from the IR, valid from DECODE onward
//  imem_ack    in   1      instruction memory done; instr valid this cycle
//  dmem_ack    in   1      data memory done; load data valid this cycle
//  imem_req    out  1      instruction fetch request
//  dmem_req    out  1      data access request
//  dmem_we     out  1      data write (store); only meaningful with dmem_req
//  ir_we       out  1      latch instruction into IR (1-cycle pulse)
//  reg_we      out  1      register file write enable (1-cycle pulse in WB)
//  pc_we       out  1      PC <= next PC (1-cycle pulse in WB)
//  busy        out  1      high in every state except IDLE and TRAP
//  trap        out  1      sticky; core halted
//  trap_cause  out  2      00 none, 01 illegal opcode, 10 imem timeout, 11 dmem timeout
//  instret     out  CNT_W  retired-instruction count
// BEHAVIOUR
//  - States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP. All outputs are registered.
//  - Reset (rst=0, any time, mid-access included):
//    - state=IDLE, all outputs 0, instret=0, timer=0.
//    - A pending req is dropped, and a later ack is ignored.
//  - IDLE: outputs 0. Go to FETCH when hold=0.
//  - FETCH: imem_req=1, held until the cycle imem_ack=1 (a same-cycle ack is legal).
//    - On ack: ir_we pulses for 1 cycle and the state goes to DECODE.
//  - DECODE (1 cycle): legal opcodes are 0010011, 0000011, 0100011, 0110011, 1100011,
//    1101111, 1100111, 0110111, 0010111.
//    - Any other opcode goes to TRAP with cause 01. A legal opcode goes to EXEC.
//  - EXEC (1 cycle): load (0000011) or store (0100011) goes to MEM; everything else goes to WB.
//  - MEM: dmem_req=1 until dmem_ack. dmem_we=1 only for a store. On ack the state goes to WB.
//  - WB (1 cycle):
//    - pc_we=1 and instret+=1 (wraps modulo 2^CNT_W).
//    - reg_we=1 unless opcode is store (0100011) or branch (1100011).
//    - Next state is IDLE if hold=1, otherwise FETCH.
//  - Latency: ALU op 5 cycles FETCH->WB with a zero-wait ack; load/store 6 cycles plus wait states.
//  - Timeout: timer clears on entry to FETCH or MEM and increments each cycle the req is
//    unacked. When MEM_TIMEOUT!=0:
//    - The timer reaching MEM_TIMEOUT with no ack goes to TRAP, cause 10 (FETCH) or 11 (MEM).
//    - An ack in the same cycle the limit is reached wins: no trap.
//  - TRAP: all enables and reqs 0, trap=1, trap_cause held. Exit only via reset.
//  - Ack inputs while the matching req=0 are ignored. hold has no effect outside WB and IDLE.
//  - Enables never overlap: at most one of ir_we, reg_we/pc_we (WB) asserts per cycle.
// STRUCTURE
//  - Shared include rv_ctrl_defs.vh: state encodings, the 9 opcode localparams (also used by
//    control_unit), and the trap cause codes.
//  - Sub-module mem_wait_timer (clear, count_en, limit-reached flag) instantiated once and
//    shared by FETCH and MEM. FSM, enables and instret stay in core_sequencer.
// TESTING
//  - ALU op, zero-wait:
//    - Stimulus: opcode=0110011, ack on the same cycle as req.
//    - Required: ir_we@c1, DECODE c2, EXEC c3, WB c4 with reg_we=pc_we=1, instret 0->1,
//      imem_req again c5.
//  - Store with 3 wait states:
//    - Stimulus: opcode=0100011, dmem_ack 3 cycles after dmem_req.
//    - Required: dmem_req=dmem_we=1 for 4 cycles, WB reg_we=0, pc_we=1.
//  - Illegal opcode:
//    - Stimulus: opcode=1111111.
//    - Required: TRAP after DECODE, trap=1, cause=01, no pc_we, no reg_we; stays there 100 cycles.
//  - Timeout (MEM_TIMEOUT=4):
//    - Stimulus: imem_ack never asserted.
//    - Required: TRAP, cause=10, after 4 req cycles.
//    - Stimulus: ack on the 4th cycle.
//    - Required: no trap.
//  - Hold and reset:
//    - Stimulus: hold=1 during WB.
//    - Required: IDLE, imem_req=0 until hold=0, then FETCH next cycle.
//    - Stimulus: rst=0 mid-MEM, followed by a stale dmem_ack.
//    - Required: all outputs 0, instret=0, the stale ack is ignored.
//  - Counter wrap (CNT_W=4):
//    - Stimulus: retire 17 ALU ops.
//    - Required: instret=1.

Source files
------------

// File: rtl/core_sequencer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | core_sequencer_pkg : state encodings, RV32I major opcodes, trap causes    |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
package core_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd6
    } state_e;

    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_IMEM    = 2'b10;
    localparam logic [1:0] CAUSE_DMEM    = 2'b11;

    function automatic logic is_legal_op(input logic [6:0] op);
        logic legal;
        case (op)
            OP_OPIMM, OP_LOAD, OP_STORE, OP_OP, OP_BRANCH,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: legal = 1'b1;
            default:                           legal = 1'b0;
        endcase
        return legal;
    endfunction

    // Stores and branches retire without touching the register file.
    function automatic logic writes_rd(input logic [6:0] op);
        return (op != OP_STORE) && (op != OP_BRANCH);
    endfunction

endpackage : core_sequencer_pkg
`default_nettype wire

// File: rtl/core_sequencer_mem_wait_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | core_sequencer_mem_wait_timer : counts unacked memory request cycles      |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module core_sequencer_mem_wait_timer #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count_en,
    output logic limit_hit
);

    generate
        if (LIMIT == 0) begin : g_disabled
            logic unused_inputs;
            assign unused_inputs = ^{clk, rst, clear, count_en};
            assign limit_hit     = 1'b0;
        end else begin : g_enabled
            localparam int CW = $clog2(LIMIT + 1);
            logic [CW-1:0] count_q;
            logic [CW-1:0] count_d;

            always_comb begin
                count_d = count_q;
                if (clear)
                    count_d = '0;
                else if (count_en)
                    count_d = count_q + CW'(1);
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst)
                    count_q <= '0;
                else
                    count_q <= count_d;
            end

            // Fires in the cycle whose unacked wait makes the count reach LIMIT.
            assign limit_hit = count_en && (count_q == CW'(LIMIT - 1));
        end
    endgenerate

endmodule : core_sequencer_mem_wait_timer
`default_nettype wire

// File: rtl/core_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | core_sequencer : multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM         |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module core_sequencer
    import core_sequencer_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hold,
    input  logic [6:0]       opcode,
    input  logic             imem_ack,
    input  logic             dmem_ack,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             ir_we,
    output logic             reg_we,
    output logic             pc_we,
    output logic             busy,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] instret
);

    state_e           state_q,    state_d;
    logic             imem_req_q, imem_req_d;
    logic             dmem_req_q, dmem_req_d;
    logic             dmem_we_q,  dmem_we_d;
    logic             ir_we_q,    ir_we_d;
    logic             reg_we_q,   reg_we_d;
    logic             pc_we_q,    pc_we_d;
    logic             busy_q,     busy_d;
    logic             trap_q,     trap_d;
    logic [1:0]       cause_q,    cause_d;
    logic [CNT_W-1:0] instret_q,  instret_d;

    logic timer_clr;
    logic timer_en;
    logic timer_hit;

    assign timer_en = (imem_req_q && !imem_ack) || (dmem_req_q && !dmem_ack);

    core_sequencer_mem_wait_timer #(
        .LIMIT (MEM_TIMEOUT)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .clear     (timer_clr),
        .count_en  (timer_en),
        .limit_hit (timer_hit)
    );

    always_comb begin
        state_d    = state_q;
        imem_req_d = 1'b0;
        dmem_req_d = 1'b0;
        dmem_we_d  = 1'b0;
        ir_we_d    = 1'b0;
        reg_we_d   = 1'b0;
        pc_we_d    = 1'b0;
        trap_d     = trap_q;
        cause_d    = cause_q;
        instret_d  = instret_q;
        timer_clr  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!hold) begin
                    state_d    = ST_FETCH;
                    imem_req_d = 1'b1;
                    timer_clr  = 1'b1;
                end
            end
            // After the ack, FETCH spends one extra cycle with ir_we high so the
            // IR holds the new instruction by the time DECODE looks at opcode.
            ST_FETCH: begin
                if (ir_we_q) begin
                    state_d = ST_DECODE;
                end else if (imem_req_q && imem_ack) begin
                    ir_we_d = 1'b1;
                end else if (timer_hit) begin
                    state_d = ST_TRAP;
                    trap_d  = 1'b1;
                    cause_d = CAUSE_IMEM;
                end else begin
                    imem_req_d = 1'b1;
                end
            end
            ST_DECODE: begin
                if (is_legal_op(opcode)) begin
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_TRAP;
                    trap_d  = 1'b1;
                    cause_d = CAUSE_ILLEGAL;
                end
            end
            ST_EXEC: begin
                if (opcode == OP_LOAD || opcode == OP_STORE) begin
                    state_d    = ST_MEM;
                    dmem_req_d = 1'b1;
                    dmem_we_d  = (opcode == OP_STORE);
                    timer_clr  = 1'b1;
                end else begin
                    state_d   = ST_WB;
                    pc_we_d   = 1'b1;
                    reg_we_d  = writes_rd(opcode);
                    instret_d = instret_q + CNT_W'(1);
                end
            end
            ST_MEM: begin
                if (dmem_req_q && dmem_ack) begin
                    state_d   = ST_WB;
                    pc_we_d   = 1'b1;
                    reg_we_d  = writes_rd(opcode);
                    instret_d = instret_q + CNT_W'(1);
                end else if (timer_hit) begin
                    state_d = ST_TRAP;
                    trap_d  = 1'b1;
                    cause_d = CAUSE_DMEM;
                end else begin
                    dmem_req_d = 1'b1;
                    dmem_we_d  = dmem_we_q;
                end
            end
            ST_WB: begin
                if (hold) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d    = ST_FETCH;
                    imem_req_d = 1'b1;
                    timer_clr  = 1'b1;
                end
            end
            ST_TRAP: begin
                state_d = ST_TRAP;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE) && (state_d != ST_TRAP);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            imem_req_q <= 1'b0;
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            ir_we_q    <= 1'b0;
            reg_we_q   <= 1'b0;
            pc_we_q    <= 1'b0;
            busy_q     <= 1'b0;
            trap_q     <= 1'b0;
            cause_q    <= CAUSE_NONE;
            instret_q  <= '0;
        end else begin
            state_q    <= state_d;
            imem_req_q <= imem_req_d;
            dmem_req_q <= dmem_req_d;
            dmem_we_q  <= dmem_we_d;
            ir_we_q    <= ir_we_d;
            reg_we_q   <= reg_we_d;
            pc_we_q    <= pc_we_d;
            busy_q     <= busy_d;
            trap_q     <= trap_d;
            cause_q    <= cause_d;
            instret_q  <= instret_d;
        end
    end

    assign imem_req   = imem_req_q;
    assign dmem_req   = dmem_req_q;
    assign dmem_we    = dmem_we_q;
    assign ir_we      = ir_we_q;
    assign reg_we     = reg_we_q;
    assign pc_we      = pc_we_q;
    assign busy       = busy_q;
    assign trap       = trap_q;
    assign trap_cause = cause_q;
    assign instret    = instret_q;

endmodule : core_sequencer
`default_nettype wire
